periph_link_ctrl: RTL and testbench

Peripheral-side transaction controller for the memory-controller serial link, and the parametrised successor to the current Peripheral block.
- Builds a framed request from an instruction, address, data and error-inject input, and hands it to the UART transmitter.
- Waits for the memory controller's response frame, which it decodes internally.
- Resolves wait/ready/retransmit responses with a bounded retry count and a response timeout, then reports success with read data or reports failure.

---
 rtl/periph_msg_pkg.sv | 33 +++
 rtl/periph_link_ctrl_if.sv | 42 ++++
 rtl/mcp_frame_decoder.sv | 42 ++++
 rtl/periph_link_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_periph_link_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_msg_pkg.sv
// periph_msg_pkg
// Shared constants and types for the peripheral side of the memory-controller
// serial link. Frame layout, MSB first:
//   SOF(8) | header(16) | data(DATA_W) | addr(ADDR_W) | error(8) | EOF(8)
// Contents: delimiter and header constants, the error-inject byte, the
// controller state enum and a small helper that recognises request headers.
package periph_msg_pkg;

  localparam logic [7:0]  SOF       = 8'h0F;
  localparam logic [7:0]  EOF       = 8'hF0;
  localparam logic [7:0]  ERR_BYTE  = 8'hFF;

  localparam logic [15:0] HDR_READ  = 16'h0001;
  localparam logic [15:0] HDR_WRITE = 16'h0002;
  localparam logic [15:0] HDR_WAIT  = 16'hFFF1;
  localparam logic [15:0] HDR_READY = 16'hFFF2;
  localparam logic [15:0] HDR_RETRY = 16'hFFF3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_RSP,
    ST_DONE,
    ST_FAIL
  } state_e;

  // True for the only two instructions the controller will put on the link.
  function automatic logic hdr_is_request(input logic [15:0] hdr);
    return (hdr == HDR_READ) || (hdr == HDR_WRITE);
  endfunction

endpackage

// File: rtl/periph_link_ctrl_if.sv
// periph_link_ctrl_if
// Bundles the request, UART and response signals of periph_link_ctrl.
// Parameters DATA_W / ADDR_W / MAX_RETRY must match the controller instance.
// Modports:
//   slave  - the controller: takes request/UART/response inputs, drives results
//   master - the host/UART side: drives requests and responses, observes results
interface periph_link_ctrl_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 24,
  parameter int MAX_RETRY = 3
);
  localparam int FRAME_W = 40 + DATA_W + ADDR_W;
  localparam int RC_W    = $clog2(MAX_RETRY + 1);

  logic               iStart;
  logic [15:0]        iInstruction;
  logic [ADDR_W-1:0]  iAddr;
  logic [DATA_W-1:0]  iData;
  logic               iError;
  logic               iTxDone;
  logic               iRxFlag;
  logic [FRAME_W-1:0] iRxMsg;

  logic               oTransmit;
  logic [FRAME_W-1:0] oOutputMsg;
  logic               oReady;
  logic               oFail;
  logic [DATA_W-1:0]  oData;
  logic               oBusy;
  logic [RC_W-1:0]    oRetryCnt;

  modport slave (
    input  iStart, iInstruction, iAddr, iData, iError, iTxDone, iRxFlag, iRxMsg,
    output oTransmit, oOutputMsg, oReady, oFail, oData, oBusy, oRetryCnt
  );

  modport master (
    output iStart, iInstruction, iAddr, iData, iError, iTxDone, iRxFlag, iRxMsg,
    input  oTransmit, oOutputMsg, oReady, oFail, oData, oBusy, oRetryCnt
  );

endinterface

// File: rtl/mcp_frame_decoder.sv
// mcp_frame_decoder
// Purely combinational field extraction for a response frame from the memory
// controller.
// Ports:
//   rx_msg   in   full response frame
//   valid    out  start and end delimiters are both correct
//   is_wait  out  header is the wait code (not qualified by valid)
//   is_ready out  header is the ready code (not qualified by valid)
//   is_retry out  header is the retransmit code (not qualified by valid)
//   data     out  data field
//   addr     out  address field
module mcp_frame_decoder
  import periph_msg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24
) (
  input  logic [40+DATA_W+ADDR_W-1:0] rx_msg,
  output logic                        valid,
  output logic                        is_wait,
  output logic                        is_ready,
  output logic                        is_retry,
  output logic [DATA_W-1:0]           data,
  output logic [ADDR_W-1:0]           addr
);
  localparam int FRAME_W = 40 + DATA_W + ADDR_W;

  logic [15:0] hdr;
  // The error byte carries no meaning on a response frame.
  logic [7:0]  err_unused;

  assign hdr        = rx_msg[FRAME_W-9 -: 16];
  assign data       = rx_msg[FRAME_W-25 -: DATA_W];
  assign addr       = rx_msg[ADDR_W+15 : 16];
  assign err_unused = rx_msg[15:8];

  assign valid    = (rx_msg[FRAME_W-1 -: 8] == SOF) && (rx_msg[7:0] == EOF);
  assign is_wait  = (hdr == HDR_WAIT);
  assign is_ready = (hdr == HDR_READY);
  assign is_retry = (hdr == HDR_RETRY);

endmodule

// File: rtl/periph_link_ctrl.sv
// periph_link_ctrl
// Peripheral-side transaction controller for the memory-controller serial link.
// Builds a request frame, hands it to the UART, waits for the response and
// resolves wait / ready / retransmit responses with a bounded retry count and a
// response timeout. Every output is registered.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   bus    slave modport of periph_link_ctrl_if (request, UART handshake,
//               response frame in; transmit pulse, request frame, ready/fail
//               pulses, read data, busy and retry count out)
module periph_link_ctrl
  import periph_msg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 24,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  periph_link_ctrl_if.slave bus
);
  localparam int FRAME_W = 40 + DATA_W + ADDR_W;
  localparam int RC_W    = $clog2(MAX_RETRY + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [15:0]        instr_q, instr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [RC_W-1:0]    retry_q, retry_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [FRAME_W-1:0] msg_q, msg_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               tx_q, tx_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               busy_q, busy_d;

  logic               dec_valid, dec_wait, dec_ready, dec_retry;
  logic [DATA_W-1:0]  dec_data;
  logic [ADDR_W-1:0]  dec_addr_unused;
  logic               rx_ok;
  logic               retransmit;

  mcp_frame_decoder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_decoder (
    .rx_msg   (bus.iRxMsg),
    .valid    (dec_valid),
    .is_wait  (dec_wait),
    .is_ready (dec_ready),
    .is_retry (dec_retry),
    .data     (dec_data),
    .addr     (dec_addr_unused)
  );

  // A frame only counts when flagged and correctly delimited.
  assign rx_ok = bus.iRxFlag && dec_valid;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    msg_d      = msg_q;
    rdata_d    = rdata_q;
    tx_d       = 1'b0;
    ready_d    = 1'b0;
    fail_d     = 1'b0;
    retransmit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          instr_d = bus.iInstruction;
          addr_d  = bus.iAddr;
          wdata_d = bus.iData;
          err_d   = bus.iError;
          retry_d = '0;
          state_d = hdr_is_request(bus.iInstruction) ? ST_SEND : ST_FAIL;
        end
      end
      ST_SEND: begin
        // retry_q is zero only on the first attempt, so the injected error
        // byte never reaches a retransmission.
        msg_d   = {SOF, instr_q, wdata_q, addr_q,
                   ((retry_q == '0) && err_q) ? ERR_BYTE : 8'h00, EOF};
        tx_d    = 1'b1;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (bus.iTxDone) begin
          tmo_d   = TMO_W'(TIMEOUT);
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        tmo_d = tmo_q - TMO_W'(1);
        // Responses are checked before the expiry so a response arriving on
        // the expiry cycle takes precedence.
        if (rx_ok && dec_wait) begin
          tmo_d = TMO_W'(TIMEOUT);
        end else if (rx_ok && dec_ready) begin
          if (instr_q == HDR_READ) rdata_d = dec_data;
          state_d = ST_DONE;
        end else if ((rx_ok && dec_retry) || (tmo_q == TMO_W'(1))) begin
          retransmit = 1'b1;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        fail_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (retransmit) begin
      if (retry_q < RC_W'(MAX_RETRY)) begin
        retry_d = retry_q + RC_W'(1);
        state_d = ST_SEND;
      end else begin
        state_d = ST_FAIL;
      end
    end

    // Registered from the next state so oBusy lines up with the state register.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      retry_q <= '0;
      tmo_q   <= '0;
      msg_q   <= '0;
      rdata_q <= '0;
      tx_q    <= 1'b0;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      msg_q   <= msg_d;
      rdata_q <= rdata_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.oTransmit  = tx_q;
  assign bus.oOutputMsg = msg_q;
  assign bus.oReady     = ready_q;
  assign bus.oFail      = fail_q;
  assign bus.oData      = rdata_q;
  assign bus.oBusy      = busy_q;
  assign bus.oRetryCnt  = retry_q;

endmodule

// File: tb/tb_periph_link_ctrl.sv
// tb_periph_link_ctrl
// Directed and randomized transactions against periph_link_ctrl. A
// transaction-level model schedules when each pulse must appear and what each
// request frame, retry count and read-data value must be.
module tb_periph_link_ctrl;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 24;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 8;
  localparam int FRAME_W   = 40 + DATA_W + ADDR_W;

  localparam logic [2:0] R_NONE = 3'd0, R_WAIT = 3'd1, R_READY = 3'd2,
                         R_RETRY = 3'd3, R_BAD = 3'd4, R_UNK = 3'd5;

  typedef struct packed {
    logic [2:0]        kind;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  periph_link_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_RETRY(MAX_RETRY)) bus ();

  periph_link_ctrl #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .MAX_RETRY (MAX_RETRY), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tx_due = -1, rdy_due = -1, fail_due = -1;
  int busy_from = 0, busy_to = 0;
  logic [DATA_W-1:0] exp_data = '0;
  rsp_t rsp_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, check the per-cycle pulses and busy
  // flag against the schedule, then return request strobes to idle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("oTransmit", 128'(bus.oTransmit), 128'(cyc == tx_due));
    chk("oReady", 128'(bus.oReady), 128'(cyc == rdy_due));
    chk("oFail", 128'(bus.oFail), 128'(cyc == fail_due));
    chk("oBusy", 128'(bus.oBusy), 128'(cyc >= busy_from && cyc < busy_to));
    bus.iStart  = 1'b0;
    bus.iTxDone = 1'b0;
    bus.iRxFlag = 1'b0;
  endtask

  task automatic push(input logic [2:0] k, input logic [DATA_W-1:0] d);
    rsp_t r;
    r.kind = k;
    r.data = d;
    rsp_q.push_back(r);
  endtask

  function automatic logic [FRAME_W-1:0] rsp_frame(input logic [2:0] k,
                                                   input logic [DATA_W-1:0] d);
    logic [15:0] h;
    logic [7:0]  s, e;
    s = 8'h0F;
    e = 8'hF0;
    case (k)
      R_WAIT:  h = 16'hFFF1;
      R_READY: h = 16'hFFF2;
      R_RETRY: h = 16'hFFF3;
      R_UNK:   h = 16'hFFF4 + 16'($urandom_range(0, 10));
      default: begin
        // A ready header with one delimiter bit flipped.
        h = 16'hFFF2;
        if ($urandom_range(0, 1) == 1) s = 8'h0F ^ (8'h01 << $urandom_range(0, 7));
        else                           e = 8'hF0 ^ (8'h01 << $urandom_range(0, 7));
      end
    endcase
    return {s, h, d, ADDR_W'($urandom), 8'($urandom), e};
  endfunction

  // One transaction. Responses are consumed from rsp_q, one per WAIT_RSP
  // cycle; an empty queue means silence. abort_at >= 0 pulls reset after that
  // many WAIT_RSP cycles of the first attempt.
  task automatic txn(input logic [15:0] instr, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic e, input int abort_at);
    int dec, att, rem, n;
    bit fin, decided, retx;
    rsp_t r;
    logic [7:0] eb;
    bus.iStart = 1'b1;
    bus.iInstruction = instr;
    bus.iAddr = a;
    bus.iData = d;
    bus.iError = e;
    dec = cyc;
    busy_from = cyc + 1;
    busy_to = 1 << 30;
    att = 0;
    n = 0;
    if (instr != 16'h0001 && instr != 16'h0002) begin
      fail_due = dec + 2;
      busy_to = dec + 2;
      while (cyc < dec + 2) tick();
      chk("bad_instr_retry", 128'(bus.oRetryCnt), 128'(0));
      chk("bad_instr_data", 128'(bus.oData), 128'(exp_data));
      rsp_q.delete();
      return;
    end
    tx_due = dec + 2;
    tick();
    // The request is latched; changing the inputs now must not matter.
    bus.iInstruction = 16'($urandom);
    bus.iAddr = ADDR_W'($urandom);
    bus.iData = DATA_W'($urandom);
    bus.iError = 1'($urandom);
    fin = 0;
    while (!fin) begin
      while (cyc < dec + 2) tick();
      eb = (att == 0 && e) ? 8'hFF : 8'h00;
      chk("frame", 128'(bus.oOutputMsg), 128'({8'h0F, instr, d, a, eb, 8'hF0}));
      chk("retry_at_tx", 128'(bus.oRetryCnt), 128'(att));
      repeat ($urandom_range(0, 3)) begin
        // Responses during WAIT_TX and a stray iStart must both be ignored.
        if ($urandom_range(0, 1) == 1) begin
          bus.iRxFlag = 1'b1;
          bus.iRxMsg = rsp_frame(R_READY, DATA_W'($urandom));
        end
        if ($urandom_range(0, 3) == 0) begin
          bus.iStart = 1'b1;
          bus.iInstruction = 16'h0001;
        end
        tick();
      end
      bus.iTxDone = 1'b1;
      tick();
      rem = TIMEOUT;
      decided = 0;
      while (!decided) begin
        if (n == abort_at) begin
          #2 reset = 1'b0;
          #1;
          chk("rst_oTransmit", 128'(bus.oTransmit), 128'(0));
          chk("rst_oReady", 128'(bus.oReady), 128'(0));
          chk("rst_oFail", 128'(bus.oFail), 128'(0));
          chk("rst_oBusy", 128'(bus.oBusy), 128'(0));
          chk("rst_oData", 128'(bus.oData), 128'(0));
          chk("rst_oOutputMsg", 128'(bus.oOutputMsg), 128'(0));
          chk("rst_oRetryCnt", 128'(bus.oRetryCnt), 128'(0));
          tx_due = -1;
          rdy_due = -1;
          fail_due = -1;
          busy_to = 0;
          exp_data = '0;
          tick();
          reset = 1'b1;
          rsp_q.delete();
          return;
        end
        n++;
        r = '0;
        if (rsp_q.size() > 0) r = rsp_q.pop_front();
        if (r.kind != R_NONE) begin
          bus.iRxFlag = 1'b1;
          bus.iRxMsg = rsp_frame(r.kind, r.data);
        end
        retx = 0;
        case (r.kind)
          R_WAIT:  rem = TIMEOUT;
          R_READY: begin
            if (instr == 16'h0001) exp_data = r.data;
            rdy_due = cyc + 2;
            busy_to = cyc + 2;
            dec = cyc;
            decided = 1;
            fin = 1;
          end
          R_RETRY: retx = 1;
          default: begin
            rem--;
            retx = (rem == 0);
          end
        endcase
        if (retx) begin
          dec = cyc;
          decided = 1;
          if (att < MAX_RETRY) begin
            att++;
            tx_due = cyc + 2;
          end else begin
            fail_due = cyc + 2;
            busy_to = cyc + 2;
            fin = 1;
          end
        end
        tick();
      end
    end
    while (cyc < dec + 2) tick();
    chk("retry_end", 128'(bus.oRetryCnt), 128'(att));
    chk("data_end", 128'(bus.oData), 128'(exp_data));
    rsp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] instr;
    int len, w;
    reset = 1'b0;
    bus.iStart = 1'b0;
    bus.iInstruction = '0;
    bus.iAddr = '0;
    bus.iData = '0;
    bus.iError = 1'b0;
    bus.iTxDone = 1'b0;
    bus.iRxFlag = 1'b0;
    bus.iRxMsg = '0;
    repeat (2) @(negedge clk);
    chk("reset_oTransmit", 128'(bus.oTransmit), 128'(0));
    chk("reset_oReady", 128'(bus.oReady), 128'(0));
    chk("reset_oFail", 128'(bus.oFail), 128'(0));
    chk("reset_oBusy", 128'(bus.oBusy), 128'(0));
    chk("reset_oData", 128'(bus.oData), 128'(0));
    chk("reset_oOutputMsg", 128'(bus.oOutputMsg), 128'(0));
    chk("reset_oRetryCnt", 128'(bus.oRetryCnt), 128'(0));
    reset = 1'b1;

    // Write with no error; data must stay 0 after the ready response.
    push(R_NONE, '0);
    push(R_READY, 32'h12345678);
    txn(16'h0002, 24'h00000F, 32'hF0F0F0F0, 1'b0, -1);
    chk("write_frame_literal", 128'(bus.oOutputMsg), 128'(96'h0F_0002_F0F0F0F0_00000F_00_F0));

    // Read with error inject, one retransmit, then ready with data.
    push(R_RETRY, '0);
    push(R_READY, 32'hABCDEFAB);
    txn(16'h0001, 24'hFFFFFF, 32'h0, 1'b1, -1);
    chk("read_retx_err_byte", 128'(bus.oOutputMsg[15:8]), 128'(8'h00));
    chk("read_data_literal", 128'(bus.oData), 128'(32'hABCDEFAB));

    // Four retransmit requests exhaust the retry budget.
    repeat (4) push(R_RETRY, '0);
    txn(16'h0002, 24'h123456, 32'h55AA55AA, 1'b0, -1);

    // Wait frame on the 5th cycle reloads; expiry 8 cycles later; then a
    // ready frame on the exact expiry cycle of the next attempt.
    repeat (4) push(R_NONE, '0);
    push(R_WAIT, '0);
    repeat (8) push(R_NONE, '0);
    repeat (7) push(R_NONE, '0);
    push(R_READY, 32'h0BADF00D);
    txn(16'h0001, 24'h000100, 32'h0, 1'b0, -1);

    // Unknown instruction, then ignored bad-delimiter / unknown-header frames.
    txn(16'h0003, 24'h000001, 32'h1, 1'b1, -1);
    push(R_BAD, 32'hDEADBEEF);
    push(R_UNK, 32'hFEEDFACE);
    push(R_BAD, 32'h01010101);
    push(R_READY, 32'hC0FFEE00);
    txn(16'h0001, 24'h00AAAA, 32'h0, 1'b0, -1);

    // Reset in WAIT_RSP, then a normal transaction.
    txn(16'h0001, 24'h000777, 32'h7, 1'b1, 3);
    push(R_READY, 32'h13572468);
    txn(16'h0001, 24'h000888, 32'h8, 1'b0, -1);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0, 1:       instr = 16'($urandom);
        2, 3, 4, 5: instr = 16'h0001;
        default:    instr = 16'h0002;
      endcase
      len = $urandom_range(0, 14);
      for (int k = 0; k < len; k++) begin
        w = $urandom_range(0, 19);
        if (w < 8)       push(R_NONE, '0);
        else if (w < 10) push(R_WAIT, '0);
        else if (w < 13) push(R_READY, DATA_W'($urandom));
        else if (w < 16) push(R_RETRY, '0);
        else if (w < 18) push(R_BAD, DATA_W'($urandom));
        else             push(R_UNK, DATA_W'($urandom));
      end
      txn(instr, ADDR_W'($urandom), DATA_W'($urandom), 1'($urandom), -1);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
